// File: rtl/n64adv2_vout_timing_mon_pkg.sv
// Shared constants for the video output timing monitor: FSM state codes, err bit indices, CRC-16 setup.
package n64adv2_vout_timing_mon_pkg;

   localparam logic [0:0] ST_WAIT_VS = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

   localparam int ERR_OVF = 0;
   localparam int ERR_DE  = 1;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/n64adv2_vout_timing_mon_crc16.sv
// One parallel CRC-16-CCITT step over a full pixel word, MSB first.
module n64adv2_vout_crc16
   import n64adv2_vout_timing_mon_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic [15:0]       crc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [15:0]       crc_o
);

   logic [15:0] c;
   logic        fb;

   always_comb begin
      c  = crc_i;
      fb = 1'b0;
      for (int i = DATA_W-1; i >= 0; i--) begin
         fb = c[15] ^ data_i[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
      crc_o = c;
   end

endmodule

// File: rtl/n64adv2_vout_timing_mon.sv
// ADV7513 output stream monitor: line/frame geometry, stability, change and error flags.
// Optional per-frame CRC of active pixels with VOUT_MON_CRC_EN defined.
module n64adv2_vout_timing_mon
   import n64adv2_vout_timing_mon_pkg::*;
#(
   parameter int color_width_o = 8,
   parameter int H_CNT_W       = 12,
   parameter int V_CNT_W       = 11,
   parameter int STABLE_FRAMES = 4
) (
   input  logic                       HDMI_CLK_w,
   input  logic                       HDMI_nRST_w,
   input  logic                       VSYNC_i,
   input  logic                       HSYNC_i,
   input  logic                       DE_i,
   input  logic [3*color_width_o-1:0] VD_i,
   input  logic                       vs_pol_i,
   input  logic                       hs_pol_i,
   output logic [H_CNT_W-1:0]         h_total_o,
   output logic [H_CNT_W-1:0]         h_active_o,
   output logic [H_CNT_W-1:0]         h_sync_o,
   output logic [V_CNT_W-1:0]         v_total_o,
   output logic [V_CNT_W-1:0]         v_active_o,
   output logic                       timing_valid_o,
   output logic                       timing_change_o,
   output logic                       frame_done_o,
   output logic [1:0]                 err_o,
   output logic [15:0]                frame_crc_o
);

   localparam int VD_W = 3*color_width_o;
   localparam int SC_W = $clog2(STABLE_FRAMES+1);
   localparam logic [H_CNT_W-1:0] H_MAX  = '1;
   localparam logic [V_CNT_W-1:0] V_MAX  = '1;
   localparam logic [SC_W-1:0]    SC_MAX = SC_W'(STABLE_FRAMES);

   logic [0:0] state;
   logic vs_a, hs_a, de_a, vs_d, hs_d, de_d;
   logic vs_le, hs_le, hs_te, de_le, de_te, meas, close;
   logic [H_CNT_W-1:0] h_cnt, hs_w, de_cnt, h_tot_l, h_sync_l, de_run_l, de_ref;
   logic [H_CNT_W-1:0] h_tot_n, h_sync_n, h_act_n;
   logic [V_CNT_W-1:0] v_cnt, v_act, v_cnt_n, v_act_n;
   logic line_de, ref_vld, de_err, ovf_any, same;
   logic h_ovf, hs_ovf, de_ovf, v_ovf, va_ovf;
   logic [1:0] err_acc, err_n;
   logic [SC_W-1:0] stable_cnt, stable_n;

   // Polarity is folded in at the input register so only active levels reach the edge detectors.
   always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w)
      if (!HDMI_nRST_w) begin
         {vs_a, hs_a, de_a, vs_d, hs_d, de_d} <= '0;
      end else begin
         vs_a <= ~(VSYNC_i ^ vs_pol_i);
         hs_a <= ~(HSYNC_i ^ hs_pol_i);
         de_a <= DE_i;
         vs_d <= vs_a;
         hs_d <= hs_a;
         de_d <= de_a;
      end

   assign vs_le = vs_a & ~vs_d;
   assign hs_le = hs_a & ~hs_d;
   assign hs_te = ~hs_a & hs_d;
   assign de_le = de_a & ~de_d;
   assign de_te = ~de_a & de_d;
   assign meas  = (state == ST_MEASURE);
   assign close = meas & vs_le;

   always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w)
      if (!HDMI_nRST_w)   state <= ST_WAIT_VS;
      else if (vs_le)     state <= ST_MEASURE;

   assign h_ovf  = ~hs_le & (h_cnt == H_MAX);
   assign hs_ovf = ~hs_le & hs_a & (hs_w == H_MAX);
   assign de_ovf = ~de_le & de_a & (de_cnt == H_MAX);
   assign v_ovf  = hs_le & (v_cnt == V_MAX);
   assign va_ovf = hs_le & line_de & (v_act == V_MAX);

   // Line-level counters run continuously; only frame accumulators are gated by the FSM.
   always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w)
      if (!HDMI_nRST_w) begin
         h_cnt    <= '0;
         hs_w     <= '0;
         de_cnt   <= '0;
         h_tot_l  <= '0;
         h_sync_l <= '0;
         de_run_l <= '0;
         line_de  <= 1'b0;
      end else begin
         if (hs_le)       h_cnt <= H_CNT_W'(1);
         else if (!h_ovf) h_cnt <= h_cnt + H_CNT_W'(1);
         if (hs_le)                  hs_w <= H_CNT_W'(1);
         else if (hs_a && !hs_ovf)   hs_w <= hs_w + H_CNT_W'(1);
         if (de_le)                  de_cnt <= H_CNT_W'(1);
         else if (de_a && !de_ovf)   de_cnt <= de_cnt + H_CNT_W'(1);
         h_tot_l  <= h_tot_n;
         h_sync_l <= h_sync_n;
         de_run_l <= h_act_n;
         line_de  <= hs_le ? de_a : (line_de | de_a);
      end

   // "_n" values fold in this cycle's events so a coincident HS edge lands in the closing frame.
   assign h_tot_n  = hs_le ? h_cnt  : h_tot_l;
   assign h_sync_n = hs_te ? hs_w   : h_sync_l;
   assign h_act_n  = de_te ? de_cnt : de_run_l;
   assign v_cnt_n  = (hs_le & ~v_ovf) ? v_cnt + V_CNT_W'(1) : v_cnt;
   assign v_act_n  = (hs_le & line_de & ~va_ovf) ? v_act + V_CNT_W'(1) : v_act;
   assign de_err   = de_te & ref_vld & (de_cnt != de_ref);
   assign ovf_any  = h_ovf | hs_ovf | de_ovf | v_ovf | va_ovf;

   always_comb begin
      err_n          = err_acc;
      err_n[ERR_OVF] = err_acc[ERR_OVF] | ovf_any;
      err_n[ERR_DE]  = err_acc[ERR_DE]  | de_err;
   end

   always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w)
      if (!HDMI_nRST_w) begin
         v_cnt   <= '0;
         v_act   <= '0;
         err_acc <= '0;
         ref_vld <= 1'b0;
         de_ref  <= '0;
      end else if (!meas || close) begin
         v_cnt   <= '0;
         v_act   <= '0;
         err_acc <= '0;
         ref_vld <= 1'b0;
         de_ref  <= '0;
      end else begin
         v_cnt   <= v_cnt_n;
         v_act   <= v_act_n;
         err_acc <= err_n;
         if (de_te && !ref_vld) begin
            ref_vld <= 1'b1;
            de_ref  <= de_cnt;
         end
      end

   // Any error blocks equality, so an overflowed frame can never count toward stability.
   assign same = (h_tot_n == h_total_o) && (h_act_n == h_active_o) && (h_sync_n == h_sync_o) &&
                 (v_cnt_n == v_total_o) && (v_act_n == v_active_o) && (err_n == 2'b00);
   assign stable_n = !same ? '0 : (stable_cnt == SC_MAX) ? SC_MAX : stable_cnt + SC_W'(1);

   always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w)
      if (!HDMI_nRST_w) begin
         h_total_o       <= '0;
         h_active_o      <= '0;
         h_sync_o        <= '0;
         v_total_o       <= '0;
         v_active_o      <= '0;
         err_o           <= '0;
         stable_cnt      <= '0;
         timing_valid_o  <= 1'b0;
         timing_change_o <= 1'b0;
         frame_done_o    <= 1'b0;
      end else begin
         frame_done_o    <= close;
         timing_change_o <= close & ~same;
         if (close) begin
            h_total_o      <= h_tot_n;
            h_active_o     <= h_act_n;
            h_sync_o       <= h_sync_n;
            v_total_o      <= v_cnt_n;
            v_active_o     <= v_act_n;
            err_o          <= err_n;
            stable_cnt     <= stable_n;
            timing_valid_o <= (stable_n == SC_MAX);
         end
      end

`ifdef VOUT_MON_CRC_EN
   logic [VD_W-1:0] vd_r;
   logic [15:0]     crc_acc, crc_step, crc_n;

   n64adv2_vout_crc16 #(.DATA_W(VD_W)) u_crc (
      .crc_i  (crc_acc),
      .data_i (vd_r),
      .crc_o  (crc_step)
   );

   assign crc_n = (meas & de_a) ? crc_step : crc_acc;

   always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w)
      if (!HDMI_nRST_w) begin
         vd_r        <= '0;
         crc_acc     <= CRC_INIT;
         frame_crc_o <= '0;
      end else begin
         vd_r <= VD_i;
         if (close) begin
            frame_crc_o <= crc_n;
            crc_acc     <= CRC_INIT;
         end else if (!meas) begin
            crc_acc <= CRC_INIT;
         end else begin
            crc_acc <= crc_n;
         end
      end
`else
   logic unused_vd;
   assign unused_vd   = ^VD_i;
   assign frame_crc_o = 16'h0000;
`endif

endmodule

// File: tb/tb_n64adv2_vout_timing_mon.sv
// Directed bench for n64adv2_vout_timing_mon using a reduced 40x10 raster (active 24x6, HS 4).
module tb_n64adv2_vout_timing_mon;

   logic        HDMI_CLK_w = 1'b0;
   logic        HDMI_nRST_w = 1'b0;
   logic        VSYNC_i = 1'b0, HSYNC_i = 1'b0, DE_i = 1'b0;
   logic [23:0] VD_i = '0;
   logic        vs_pol_i = 1'b1, hs_pol_i = 1'b1;
   logic [11:0] h_total_o, h_active_o, h_sync_o;
   logic [10:0] v_total_o, v_active_o;
   logic        timing_valid_o, timing_change_o, frame_done_o;
   logic [1:0]  err_o;
   logic [15:0] frame_crc_o;

   n64adv2_vout_timing_mon dut (
      .HDMI_CLK_w(HDMI_CLK_w), .HDMI_nRST_w(HDMI_nRST_w),
      .VSYNC_i(VSYNC_i), .HSYNC_i(HSYNC_i), .DE_i(DE_i), .VD_i(VD_i),
      .vs_pol_i(vs_pol_i), .hs_pol_i(hs_pol_i),
      .h_total_o(h_total_o), .h_active_o(h_active_o), .h_sync_o(h_sync_o),
      .v_total_o(v_total_o), .v_active_o(v_active_o),
      .timing_valid_o(timing_valid_o), .timing_change_o(timing_change_o),
      .frame_done_o(frame_done_o), .err_o(err_o), .frame_crc_o(frame_crc_o)
   );

   always #5 HDMI_CLK_w = ~HDMI_CLK_w;

   typedef struct {
      int vtot; int bad; int stall; bit pix;
      int ht; int vt; bit v; bit c; logic [1:0] e;
   } vec_t;

   typedef struct {
      logic [11:0] ht, ha, hs; logic [10:0] vt, va;
      logic v, c; logic [1:0] e; logic [15:0] crc;
   } cap_t;

   cap_t caps[$];
   vec_t vecs[21];
   int   n_tests = 0, n_fail = 0, orphan_chg = 0;

   always begin
      @(posedge HDMI_CLK_w);
      #1;
      if (frame_done_o === 1'b1)
         caps.push_back('{h_total_o, h_active_o, h_sync_o, v_total_o, v_active_o,
                          timing_valid_o, timing_change_o, err_o, frame_crc_o});
      else if (timing_change_o !== 1'b0)
         orphan_chg++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int vtot, int bad, int stall, bit pix, int ht, int vt,
                               bit v, bit c, logic [1:0] e);
      vec_t r;
      r.vtot = vtot; r.bad = bad; r.stall = stall; r.pix = pix;
      r.ht = ht; r.vt = vt; r.v = v; r.c = c; r.e = e;
      return r;
   endfunction

   // One line: HS active clocks 0..3, DE from clock 6 for de_len clocks, then extra idle clocks.
   task automatic drive_line(input bit vs, input int de_len, input int extra, input bit pix);
      for (int c = 0; c < 40 + extra; c++) begin
         @(negedge HDMI_CLK_w);
         VSYNC_i = ~(vs ^ vs_pol_i);
         HSYNC_i = ~((c < 4) ^ hs_pol_i);
         DE_i    = (de_len > 0) && (c >= 6) && (c < 6 + de_len);
         VD_i    = (pix && c == 6) ? 24'h000001 : 24'h000000;
      end
   endtask

   task automatic drive_frame(input vec_t f);
      for (int l = 0; l < f.vtot; l++)
         drive_line(l < 2, (l >= 2 && l < 8) ? ((l == f.bad) ? 23 : 24) : 0,
                    (l == f.vtot - 1) ? f.stall : 0, f.pix && (l == 2));
   endtask

   initial begin
      vec_t std_f;
      int   n0;
      logic any_crc;
      std_f = mk(10, -1, 0, 0, 40, 10, 0, 0, 2'b00);
      vecs[0]  = mk(10, -1, 0,    0, 40,   10, 0, 1, 2'b00);
      vecs[1]  = std_f;
      vecs[2]  = std_f;
      vecs[3]  = std_f;
      vecs[4]  = mk(10, -1, 0,    0, 40,   10, 1, 0, 2'b00);
      vecs[5]  = mk(10, -1, 0,    0, 40,   10, 1, 0, 2'b00);
      vecs[6]  = mk(9,  -1, 0,    0, 40,   9,  0, 1, 2'b00);
      vecs[7]  = mk(9,  -1, 0,    0, 40,   9,  0, 0, 2'b00);
      vecs[8]  = mk(9,  -1, 0,    0, 40,   9,  0, 0, 2'b00);
      vecs[9]  = mk(9,  -1, 0,    0, 40,   9,  0, 0, 2'b00);
      vecs[10] = mk(9,  -1, 0,    0, 40,   9,  1, 0, 2'b00);
      vecs[11] = mk(10, -1, 0,    0, 40,   10, 0, 1, 2'b00);
      vecs[12] = mk(10, -1, 0,    1, 40,   10, 0, 0, 2'b00);
      vecs[13] = mk(10, 4,  0,    0, 40,   10, 0, 1, 2'b10);
      vecs[14] = std_f;
      vecs[15] = mk(10, -1, 5000, 0, 4095, 10, 0, 1, 2'b01);
      vecs[16] = mk(10, -1, 0,    0, 40,   10, 0, 1, 2'b00);
      vecs[17] = std_f;
      vecs[18] = std_f;
      vecs[19] = std_f;
      vecs[20] = mk(10, -1, 0,    0, 40,   10, 1, 0, 2'b00);

      repeat (3) @(negedge HDMI_CLK_w);
      check("reset outputs", {h_total_o, h_active_o, h_sync_o, v_total_o, v_active_o},  32'd0);
      check("reset flags", {timing_valid_o, timing_change_o, frame_done_o, err_o}, 32'd0);
      HDMI_nRST_w = 1'b1;

      for (int i = 0; i < 21; i++) drive_frame(vecs[i]);
      drive_frame(std_f);
      check("close count", caps.size(), 21);
      for (int i = 0; i < 21 && i < caps.size(); i++) begin
         check($sformatf("f%0d h_total", i),  caps[i].ht, vecs[i].ht);
         check($sformatf("f%0d h_active", i), caps[i].ha, 24);
         check($sformatf("f%0d h_sync", i),   caps[i].hs, 4);
         check($sformatf("f%0d v_total", i),  caps[i].vt, vecs[i].vt);
         check($sformatf("f%0d v_active", i), caps[i].va, 6);
         check($sformatf("f%0d valid", i),    caps[i].v,  vecs[i].v);
         check($sformatf("f%0d change", i),   caps[i].c,  vecs[i].c);
         check($sformatf("f%0d err", i),      caps[i].e,  vecs[i].e);
      end
      check("change without close", orphan_chg, 0);

`ifdef VOUT_MON_CRC_EN
      if (caps.size() >= 13) begin
         check("crc equal frames", caps[4].crc == caps[5].crc, 1);
         check("crc pixel change", caps[12].crc != caps[11].crc, 1);
      end
`else
      any_crc = 1'b0;
      foreach (caps[i]) any_crc = any_crc | (|caps[i].crc);
      check("crc tied off", any_crc, 0);
`endif

      // Reset in the middle of the frame following the terminator.
      repeat (3) drive_line(0, 24, 0, 0);
      check("pre-reset valid", timing_valid_o, 1);
      check("pre-reset h_total", h_total_o, 40);
      #2 HDMI_nRST_w = 1'b0;
      #1;
      check("mid-frame reset outputs", {h_total_o, h_active_o, h_sync_o, v_total_o, v_active_o}, 32'd0);
      check("mid-frame reset flags", {timing_valid_o, timing_change_o, frame_done_o, err_o}, 32'd0);
      vs_pol_i = 1'b0;
      hs_pol_i = 1'b0;
      repeat (2) drive_line(0, 24, 0, 0);
      HDMI_nRST_w = 1'b1;
      repeat (2) drive_line(0, 24, 0, 0);
      n0 = caps.size();
      drive_frame(std_f);
      check("no close at opening VS", caps.size(), n0);
      drive_frame(std_f);
      check("first close after reset", caps.size(), n0 + 1);
      if (caps.size() > n0) begin
         check("post-reset h_total",  caps[n0].ht, 40);
         check("post-reset h_sync",   caps[n0].hs, 4);
         check("post-reset v_total",  caps[n0].vt, 10);
         check("post-reset v_active", caps[n0].va, 6);
         check("post-reset change",   caps[n0].c,  1);
         check("post-reset valid",    caps[n0].v,  0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
